// File: rtl/mont_mul_pkg.sv
// Shared types and constants for the Montgomery multiplier arbiter.
//   state_t   : arbiter FSM states
//   ERR_*     : response error codes carried on rsp_err
//   msz_width : width of an m_size field for a given operand width
package mont_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_FLUSH
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BADOP   = 2'b10;

    function automatic int msz_width(input int nbits);
        return $clog2(nbits) + 3;
    endfunction

endpackage

// File: rtl/mont_mul_arbiter_if.sv
// Bus bundle between the requesters/core and the arbiter.
//   req_*  : NREQ requesters, operands flattened at [i*NBITS +: NBITS]
//   rsp_*  : single shared response channel
//   core_* : Montgomery multiplier core connection
// slave  : arbiter side.  master : requester/core side.
interface mont_mul_arbiter_if #(
    parameter int NBITS = 4096,
    parameter int NREQ  = 4,
    parameter int MSZW  = mont_mul_pkg::msz_width(NBITS),
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*NBITS-1:0] req_a;
    logic [NREQ*NBITS-1:0] req_b;
    logic [NREQ*NBITS-1:0] req_m;
    logic [NREQ*MSZW-1:0]  req_m_size;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [NBITS-1:0]      rsp_y;
    logic [1:0]            rsp_err;

    logic                  core_rst_n;
    logic                  core_enable_p;
    logic [NBITS-1:0]      core_a;
    logic [NBITS-1:0]      core_b;
    logic [NBITS-1:0]      core_m;
    logic [MSZW-1:0]       core_m_size;
    logic [NBITS-1:0]      core_y;
    logic                  core_done_irq_p;

    modport slave (
        input  req_valid, req_a, req_b, req_m, req_m_size,
        output req_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_err,
        input  rsp_ready,
        output core_rst_n, core_enable_p, core_a, core_b, core_m, core_m_size,
        input  core_y, core_done_irq_p
    );

    modport master (
        output req_valid, req_a, req_b, req_m, req_m_size,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_err,
        output rsp_ready,
        input  core_rst_n, core_enable_p, core_a, core_b, core_m, core_m_size,
        output core_y, core_done_irq_p
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector        ptr : highest-priority index
//   en  : grant enable          gnt : one-hot grant
//   idx : encoded grant index   any : a grant was made
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW:0]      sum;

    always_comb begin
        // Rotate so that bit k of rot is requester (ptr+k) mod NREQ.
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        idx = '0;
        any = 1'b0;
        sum = '0;
        // Walk downward so the lowest rotated offset is the final winner.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (en && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IDW+1)'(k);
                idx = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one Montgomery multiplier core between NREQ requesters.
// Round-robin grant, operand validation, single in-flight operation,
// watchdog that resets a hung core, one shared response channel.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : mont_mul_arbiter_if.slave (requests, response, core port)
module mont_mul_arbiter
    import mont_mul_pkg::*;
#(
    parameter int NBITS   = 4096,
    parameter int NREQ    = 4,
    parameter int MSZW    = msz_width(NBITS),
    parameter int TIMEOUT = 65535,
    parameter int IDW     = $clog2(NREQ)
) (
    input logic              clk,
    input logic              rst,
    mont_mul_arbiter_if.slave bus
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_q;
    logic [NBITS-1:0]  op_a, op_b, op_m, y_q;
    logic [MSZW-1:0]   op_msz;
    logic [1:0]        err_q;
    logic [WDW-1:0]    wd_cnt;
    logic              flush_cnt;

    logic              arb_en, arb_any;
    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic [NBITS-1:0]  sel_a, sel_b, sel_m;
    logic [MSZW-1:0]   sel_msz;
    logic              bad_op, wd_expired, done;
    logic              enable_p, rsp_vld, core_rst_n_c;

    // Grants only from IDLE; rst keeps req_ready low during reset.
    assign arb_en = (state == ST_IDLE) && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_m   = '0;
        sel_msz = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                sel_a   = bus.req_a[i*NBITS +: NBITS];
                sel_b   = bus.req_b[i*NBITS +: NBITS];
                sel_m   = bus.req_m[i*NBITS +: NBITS];
                sel_msz = bus.req_m_size[i*MSZW +: MSZW];
            end
        end
    end

    // Montgomery needs an odd modulus that fits in m_size bits and
    // fully reduced operands; anything else would return garbage.
    always_comb begin
        bad_op = 1'b0;
        if (!op_m[0])                   bad_op = 1'b1;
        if (op_msz == '0)               bad_op = 1'b1;
        if (op_msz > MSZW'(NBITS))      bad_op = 1'b1;
        if ((op_m >> op_msz) != '0)     bad_op = 1'b1;
        if (op_a >= op_m)               bad_op = 1'b1;
        if (op_b >= op_m)               bad_op = 1'b1;
    end

    assign done       = bus.core_done_irq_p;
    // wd_cnt is 0 in the first WAIT cycle, so TIMEOUT-1 marks the last one.
    assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        enable_p      = 1'b0;
        rsp_vld       = 1'b0;
        core_rst_n_c  = !rst;
        case (state)
            ST_IDLE:  if (arb_any) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = bad_op ? ST_RESP : ST_ISSUE;
            ST_ISSUE: begin
                enable_p  = 1'b1;
                state_nxt = ST_WAIT;
            end
            // done is tested first so it wins over a same-cycle timeout.
            ST_WAIT: begin
                if (done)            state_nxt = ST_RESP;
                else if (wd_expired) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                core_rst_n_c = 1'b0;
                if (flush_cnt) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            id_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_m      <= '0;
            op_msz    <= '0;
            y_q       <= '0;
            err_q     <= ERR_OK;
            wd_cnt    <= '0;
            flush_cnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_m   <= sel_m;
                        op_msz <= sel_msz;
                        id_q   <= arb_idx;
                        rr_ptr <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (bad_op) begin
                        y_q   <= '0;
                        err_q <= ERR_BADOP;
                    end
                end
                ST_ISSUE: wd_cnt <= '0;
                ST_WAIT: begin
                    if (done) begin
                        y_q   <= bus.core_y;
                        err_q <= ERR_OK;
                    end else if (wd_expired) begin
                        y_q       <= '0;
                        err_q     <= ERR_TIMEOUT;
                        flush_cnt <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_FLUSH: flush_cnt <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = arb_gnt;
    assign bus.rsp_valid     = rsp_vld;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_y         = y_q;
    assign bus.rsp_err       = err_q;
    assign bus.core_rst_n    = core_rst_n_c;
    assign bus.core_enable_p = enable_p;
    assign bus.core_a        = op_a;
    assign bus.core_b        = op_b;
    assign bus.core_m        = op_m;
    assign bus.core_m_size   = op_msz;

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter with a behavioural core and a
// response scoreboard.
module tb_mont_mul_arbiter;
    import mont_mul_pkg::*;

    localparam int NBITS   = 8;
    localparam int NREQ    = 4;
    localparam int MSZW    = msz_width(NBITS);
    localparam int TIMEOUT = 16;
    localparam int IDW     = $clog2(NREQ);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [NBITS-1:0] y;
        logic [1:0]       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mont_mul_arbiter_if #(.NBITS(NBITS), .NREQ(NREQ), .MSZW(MSZW), .IDW(IDW)) bus ();

    mont_mul_arbiter #(
        .NBITS(NBITS), .NREQ(NREQ), .MSZW(MSZW), .TIMEOUT(TIMEOUT), .IDW(IDW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   opa [NREQ];
    int   opb [NREQ];
    int   opm [NREQ];
    int   opsz[NREQ];
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always_comb begin
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_m      = '0;
        bus.req_m_size = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*NBITS +: NBITS]     = NBITS'(opa[i]);
            bus.req_b[i*NBITS +: NBITS]     = NBITS'(opb[i]);
            bus.req_m[i*NBITS +: NBITS]     = NBITS'(opm[i]);
            bus.req_m_size[i*MSZW +: MSZW]  = MSZW'(opsz[i]);
        end
    end

    // Reference: y = a*b*2^-msz mod m, by search over residues.
    function automatic int ref_y(int a, int b, int m, int msz);
        int p, r;
        if (m <= 0) return 0;
        p = (a * b) % m;
        r = 1 % m;
        for (int i = 0; i < msz; i++) r = (r * 2) % m;
        for (int x = 0; x < m; x++) if ((x * r) % m == p) return x;
        return 0;
    endfunction

    function automatic logic [1:0] ref_err(int a, int b, int m, int msz);
        if (m % 2 == 0 || msz == 0 || msz > NBITS || (m >> msz) != 0 || a >= m || b >= m)
            return ERR_BADOP;
        return ERR_OK;
    endfunction

    // Behavioural core: fixed latency, or never finishes when hung.
    int               core_lat  = 10;
    bit               core_hang = 1'b0;
    logic             busy, core_done, stray_done;
    int               lat_cnt;
    logic [NBITS-1:0] y_reg;

    assign bus.core_y          = y_reg;
    assign bus.core_done_irq_p = core_done | stray_done;

    always @(posedge clk) begin
        if (bus.core_rst_n !== 1'b1) begin
            busy      <= 1'b0;
            core_done <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (bus.core_enable_p === 1'b1 && !busy) begin
                busy    <= 1'b1;
                lat_cnt <= core_lat;
                y_reg   <= NBITS'(ref_y(int'(bus.core_a), int'(bus.core_b),
                                        int'(bus.core_m), int'(bus.core_m_size)));
            end else if (busy && !core_hang) begin
                if (lat_cnt == 1) begin
                    busy      <= 1'b0;
                    core_done <= 1'b1;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    // Mid-cycle monitor of enable pulses and core reset runs outside rst.
    int cyc_n = 0, en_cnt = 0, en_cyc = 0, low_run = 0, last_low_run = 0, flush_start = 0;
    always @(negedge clk) begin
        cyc_n <= cyc_n + 1;
        if (bus.core_enable_p === 1'b1) begin
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc_n;
        end
        if (rst === 1'b0 && bus.core_rst_n === 1'b0) begin
            if (low_run == 0) flush_start <= cyc_n;
            low_run <= low_run + 1;
        end else if (low_run != 0) begin
            last_low_run <= low_run;
            low_run      <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input int a, input int b, input int m, input int msz);
        opa[id]  = a;
        opb[id]  = b;
        opm[id]  = m;
        opsz[id] = msz;
    endtask

    function automatic exp_t model(input int id);
        exp_t e;
        e.id  = IDW'(id);
        e.err = ref_err(opa[id], opb[id], opm[id], opsz[id]);
        if (e.err == ERR_OK && core_hang) e.err = ERR_TIMEOUT;
        e.y   = (e.err == ERR_OK) ? NBITS'(ref_y(opa[id], opb[id], opm[id], opsz[id])) : '0;
        return e;
    endfunction

    // Wait for a grant, check it targets id, record expectation, accept.
    task automatic take(input int id, input string tag);
        int n = 0;
        #1;
        while (bus.req_ready === '0 && n < 50) begin cyc(); n++; end
        chk(tag, 32'(bus.req_ready), 32'(1 << id));
        sb.push_back(model(id));
        cyc();
    endtask

    task automatic get_rsp(input string tag);
        int   n = 0;
        exp_t e;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin cyc(); n++; end
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s_unexpected got=rsp want=none", tag);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk({tag, "_id"},  32'(bus.rsp_id),  32'(e.id));
        chk({tag, "_y"},   32'(bus.rsp_y),   32'(e.y));
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        int   e0, n, hits;
        exp_t dump;
        logic [IDW-1:0]   cap_id;
        logic [NBITS-1:0] cap_y;
        logic [1:0]       cap_err;
        int   order[5] = '{0, 1, 2, 3, 0};

        stray_done    = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, 1, 1, 7, 3);
        bus.req_valid = '1;
        rst = 1'b1;

        // Reset state, with every requester asserting valid.
        cyc(); cyc();
        chk("rst_req_ready",  32'(bus.req_ready),     32'd0);
        chk("rst_core_rst_n", 32'(bus.core_rst_n),    32'd0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),     32'd0);
        chk("rst_enable",     32'(bus.core_enable_p), 32'd0);
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("post_rst_core_rst_n", 32'(bus.core_rst_n),  32'd1);
        chk("rst_rsp_id",          32'(bus.rsp_id),      32'd0);
        chk("rst_rsp_y",           32'(bus.rsp_y),       32'd0);
        chk("rst_rsp_err",         32'(bus.rsp_err),     32'd0);
        chk("rst_core_a",          32'(bus.core_a),      32'd0);
        chk("rst_core_m",          32'(bus.core_m),      32'd0);
        chk("rst_core_m_size",     32'(bus.core_m_size), 32'd0);

        // Single op: 3*5*8^-1 mod 7 = 1.
        e0 = en_cnt;
        set_op(0, 3, 5, 7, 3);
        bus.req_valid[0] = 1'b1;
        take(0, "single_grant");
        bus.req_valid[0] = 1'b0;
        get_rsp("single");
        chk("single_enable_pulses", 32'(en_cnt - e0), 32'd1);

        // Round robin from rr_ptr=0 with everyone continuously valid.
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2, 11, 4);
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            take(order[k], "rr_grant");
            get_rsp("rr");
        end
        bus.req_valid = 4'b0010;
        take(1, "rr_solo");
        get_rsp("rr_solo");
        bus.req_valid = 4'b1010;
        take(3, "rr_ptr2_first");
        get_rsp("rr_ptr2_first");
        take(1, "rr_ptr2_second");
        bus.req_valid = '0;
        get_rsp("rr_ptr2_second");

        // Bad operands: even modulus, then m_size beyond NBITS.
        for (int t = 0; t < 2; t++) begin
            e0 = en_cnt;
            if (t == 0) set_op(0, 3, 5, 6, 3);
            else        set_op(0, 3, 5, 7, 9);
            bus.req_valid[0] = 1'b1;
            take(0, "bad_grant");
            bus.req_valid[0] = 1'b0;
            chk("bad_valid_accept_plus1", 32'(bus.rsp_valid), 32'd0);
            cyc();
            chk("bad_valid_accept_plus2", 32'(bus.rsp_valid), 32'd1);
            get_rsp("bad");
            chk("bad_no_enable", 32'(en_cnt - e0), 32'd0);
        end

        // Watchdog: hung core, then a normal op afterwards.
        core_hang = 1'b1;
        set_op(0, 2, 3, 13, 4);
        bus.req_valid[0] = 1'b1;
        take(0, "to_grant");
        bus.req_valid[0] = 1'b0;
        get_rsp("timeout");
        chk("to_flush_len",   32'(last_low_run),         32'd2);
        chk("to_wait_cycles", 32'(flush_start - en_cyc), 32'(TIMEOUT + 1));
        core_hang = 1'b0;
        bus.req_valid[0] = 1'b1;
        take(0, "after_to_grant");
        bus.req_valid[0] = 1'b0;
        get_rsp("after_to");

        // Backpressure with requester 2 waiting.
        bus.rsp_ready = 1'b0;
        set_op(0, 4, 9, 11, 4);
        bus.req_valid[0] = 1'b1;
        take(0, "bp_grant0");
        bus.req_valid[0] = 1'b0;
        set_op(2, 5, 6, 11, 3);
        bus.req_valid[2] = 1'b1;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 100) begin cyc(); n++; end
        cap_id  = bus.rsp_id;
        cap_y   = bus.rsp_y;
        cap_err = bus.rsp_err;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid",     32'(bus.rsp_valid), 32'd1);
            chk("bp_id_stable", 32'(bus.rsp_id),    32'(cap_id));
            chk("bp_y_stable",  32'(bus.rsp_y),     32'(cap_y));
            chk("bp_err_stable",32'(bus.rsp_err),   32'(cap_err));
            chk("bp_no_ready",  32'(bus.req_ready), 32'd0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        get_rsp("bp_first");
        chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
        take(2, "bp_grant2");
        bus.req_valid[2] = 1'b0;
        get_rsp("bp_second");

        // Reset mid-WAIT: request dropped, stray done ignored.
        e0 = en_cnt;
        set_op(0, 6, 5, 13, 4);
        bus.req_valid[0] = 1'b1;
        take(0, "mid_grant");
        bus.req_valid[0] = 1'b0;
        n = 0;
        while (en_cnt == e0 && n < 20) begin cyc(); n++; end
        chk("mid_enable_seen", 32'(en_cnt - e0), 32'd1);
        cyc(); cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("mid_core_rst_n_low", 32'(bus.core_rst_n), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        dump = sb.pop_back();
        chk("mid_rsp_valid",  32'(bus.rsp_valid),     32'd0);
        chk("mid_rsp_id",     32'(bus.rsp_id),        32'd0);
        chk("mid_rsp_y",      32'(bus.rsp_y),         32'd0);
        chk("mid_rsp_err",    32'(bus.rsp_err),       32'd0);
        chk("mid_core_a",     32'(bus.core_a),        32'd0);
        chk("mid_core_msz",   32'(bus.core_m_size),   32'd0);
        chk("mid_enable",     32'(bus.core_enable_p), 32'd0);
        chk("mid_core_rst_n", 32'(bus.core_rst_n),    32'd1);
        e0 = en_cnt;
        stray_done = 1'b1;
        cyc();
        stray_done = 1'b0;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.rsp_valid !== 1'b0) hits++;
            cyc();
        end
        chk("stray_no_rsp",    32'(hits),          32'd0);
        chk("stray_no_enable", 32'(en_cnt - e0),   32'd0);
        set_op(1, 7, 8, 11, 4);
        bus.req_valid[1] = 1'b1;
        take(1, "recover_grant");
        bus.req_valid[1] = 1'b0;
        get_rsp("recover");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mont_mul_arbiter.md
Name: mont_mul_arbiter

Overview:
Shares one Montgomery multiplier core (ports enable_p, a, b, m, m_size, y, done_irq_p) between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Checks the operands before issuing, pulses the core's enable_p, and waits for done_irq_p.
- Returns the result with the requester ID through a single response channel.
- A watchdog recovers a hung core by pulsing the core's active-low reset.

Parameters:
NBITS, 4096, operand/modulus width
NREQ, 4, number of requesters (2..8)
MSZW, $clog2(NBITS)+3, m_size field width
TIMEOUT, 65535, max WAIT cycles before the core is declared hung
IDW, $clog2(NREQ), requester ID width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (at most one bit high)
req_a  in  NREQ*NBITS  operand A, requester i at [i*NBITS +: NBITS]
req_b  in  NREQ*NBITS  operand B
req_m  in  NREQ*NBITS  modulus
req_m_size  in  NREQ*MSZW  modulus bit-size
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester ID
rsp_y  out  NBITS  result a*b*2^-m_size mod m
rsp_err  out  2  00 ok, 01 timeout, 10 bad operands
core_rst_n  out  1  core reset (active low)
core_enable_p  out  1  core start pulse
core_a  out  NBITS  registered operand A
core_b  out  NBITS  registered operand B
core_m  out  NBITS  registered modulus
core_m_size  out  MSZW  registered m_size
core_y  in  NBITS  core result
core_done_irq_p  in  1  core done pulse, one cycle

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE, rr_ptr=0.
  - All req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0.
  - core_enable_p=0, core_a/b/m=0, core_m_size=0, core_rst_n=0 during rst and 1 afterwards.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP, FLUSH.
- IDLE:
  - Grant the first valid requester searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[g] is combinational (same cycle as req_valid[g]) and only in IDLE.
  - On grant: latch operands into core_* registers, latch g as id, set rr_ptr=(g+1)%NREQ, go to CHECK.
- CHECK (one cycle): operands are bad if any holds:
  - m[0]==0
  - m_size==0
  - m_size>NBITS
  - m>>m_size != 0
  - a>=m
  - b>=m

  Bad operands: rsp_err=10, rsp_y=0, go to RESP; the core is never enabled. Otherwise go to ISSUE.
- ISSUE: core_enable_p=1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - core_a/b/m/m_size are held stable.
  - On core_done_irq_p: capture core_y into rsp_y, rsp_err=00, go to RESP.
  - The counter increments each cycle. On reaching TIMEOUT without done: rsp_err=01, rsp_y=0, go to FLUSH.
  - If done and timeout occur in the same cycle, done wins.
- FLUSH: core_rst_n=0 for exactly 2 cycles, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_y/rsp_err are held stable until rsp_ready.
  - The handshake completes on rsp_valid&&rsp_ready; go to IDLE next cycle.
  - No new grant occurs while in RESP.
- core_done_irq_p outside WAIT is ignored.
- Minimum latency from request accept to rsp_valid: accept cycle + CHECK + ISSUE + core cycles + 1.
- Bad-operand latency: rsp_valid 2 cycles after accept.
- rst mid-operation: return to IDLE, drop the in-flight request with no response, and hold core_rst_n=0 during rst.
- Requester fairness: a continuously valid requester is granted within NREQ grants.

Decomposition:
- Package mont_mul_pkg:
  - State enum.
  - Error code constants ERR_OK/ERR_TIMEOUT/ERR_BADOP.
  - MSZW derivation function.
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, ptr, enable. Outputs: one-hot grant, encoded index, any.
  - Purely combinational.
- Operand checking and the FSM stay in mont_mul_arbiter.

Test Plan:
- Single op: NBITS=8, requester 0, a=3, b=5, m=7, m_size=3, behavioural core with 10-cycle latency -> exactly one enable_p pulse; rsp_id=0, rsp_y=1 (15*8^-1 mod 7), rsp_err=00.
- Round robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0. Then with only req 1 and req 3 valid, and rr_ptr=2 -> 3 then 1.
- Bad operands:
  - m=6 -> rsp_err=10, rsp_y=0, rsp_valid 2 cycles after accept, enable_p never asserted.
  - m=7, m_size=9 -> same response.
- Timeout: TIMEOUT=16, core stub never asserts done -> rsp_err=01 after 16 WAIT cycles; core_rst_n low for exactly 2 cycles; next request completes normally.
- Backpressure: rsp_ready held low 5 cycles with req 2 valid -> rsp fields stable, req_ready all 0; req 2 granted the cycle after the handshake returns to IDLE.
- Reset mid-WAIT: assert rst for 1 cycle -> no response emitted, outputs at reset values, core_rst_n=0 during rst; a stray done pulse afterwards is ignored.
